// File: rtl/apb_sensor_monitor_pkg.sv
// Shared register map, channel state record and APB response states for apb_sensor_monitor.
package sensor_monitor_pkg;

    localparam int ADDR_WIDTH = 12;

    localparam logic [ADDR_WIDTH-1:0] REG_ALARM_STATUS = 12'h000;
    localparam logic [ADDR_WIDTH-1:0] REG_IRQ_EN       = 12'h002;
    localparam logic [ADDR_WIDTH-1:0] REG_CTRL         = 12'h004;
    localparam logic [ADDR_WIDTH-1:0] REG_INFO         = 12'h006;
    localparam logic [ADDR_WIDTH-1:0] CHAN_BASE        = 12'h020;
    localparam logic [ADDR_WIDTH-1:0] CHAN_STRIDE      = 12'h010;

    localparam logic [3:0] CH_VALUE     = 4'h0;
    localparam logic [3:0] CH_MIN       = 4'h2;
    localparam logic [3:0] CH_MAX       = 4'h4;
    localparam logic [3:0] CH_THRESH_LO = 4'h6;
    localparam logic [3:0] CH_THRESH_HI = 4'h8;
    localparam logic [3:0] CH_FLAGS     = 4'hA;
    localparam logic [3:0] CH_AVG       = 4'hC;

    // Fields are 16 bits wide so narrower channels read back zero-extended.
    typedef struct packed {
        logic [15:0] value;
        logic [15:0] min;
        logic [15:0] max;
        logic [15:0] thresh_lo;
        logic [15:0] thresh_hi;
        logic        seen;
    } chan_state_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } apb_state_t;

endpackage

// File: rtl/apb_sensor_monitor_if.sv
// 16-bit management APB bus carrying its own clock and asynchronous active-low reset.
interface apb_sensor_monitor_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input logic pclk,
    input logic preset_n
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  pclk, preset_n, prdata, pready, pslverr,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_sensor_monitor_channel_tracker.sv
// One sensor channel: latest sample, min/max, alarm thresholds and compare.
// The EMA accumulator exists only when SENSOR_MONITOR_AVERAGING_EN is defined.
module sensor_channel_tracker
    import sensor_monitor_pkg::*;
#(
    parameter int SENSOR_WIDTH = 16,
    parameter int AVG_SHIFT    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic [SENSOR_WIDTH-1:0] sample_i,
    input  logic                    clr_i,
    input  logic                    thr_lo_we_i,
    input  logic                    thr_hi_we_i,
    input  logic [SENSOR_WIDTH-1:0] wdata_i,
    output chan_state_t             state_o,
    output logic                    oor_o,
    output logic                    alarm_set_o
`ifdef SENSOR_MONITOR_AVERAGING_EN
    ,
    output logic [SENSOR_WIDTH-1:0] avg_o
`endif
);

    if (AVG_SHIFT < 0 || AVG_SHIFT > 8) begin : g_bad_shift
        $error("sensor_channel_tracker: AVG_SHIFT out of range");
    end

    logic [SENSOR_WIDTH-1:0] value_q, min_q, max_q, lo_q, hi_q;
    logic                    seen_q, oor_q;
    logic                    cmp_s;

    // Alarm set is combinational so status rises on the same edge VALUE updates.
    assign cmp_s       = (sample_i < lo_q) || (sample_i > hi_q);
    assign alarm_set_o = valid_i && cmp_s;

    // Sample, min/max, threshold and out-of-range flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            min_q   <= '0;
            max_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '1;
            seen_q  <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            if (thr_lo_we_i) lo_q <= wdata_i;
            if (thr_hi_we_i) hi_q <= wdata_i;
            if (valid_i) begin
                value_q <= sample_i;
                oor_q   <= cmp_s;
            end
            if (clr_i) begin
                seen_q <= 1'b0;
                min_q  <= '0;
                max_q  <= '0;
            end else if (valid_i) begin
                if (!seen_q) begin
                    min_q  <= sample_i;
                    max_q  <= sample_i;
                    seen_q <= 1'b1;
                end else begin
                    if (sample_i < min_q) min_q <= sample_i;
                    if (sample_i > max_q) max_q <= sample_i;
                end
            end
        end
    end

`ifdef SENSOR_MONITOR_AVERAGING_EN
    localparam int ACC_WIDTH = SENSOR_WIDTH + AVG_SHIFT;
    logic [ACC_WIDTH-1:0] acc_q;

    // EMA accumulator; a strobe coinciding with a clear is ignored like for min/max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (valid_i && !clr_i) begin
            if (!seen_q) acc_q <= ACC_WIDTH'(sample_i) << AVG_SHIFT;
            else         acc_q <= acc_q + ACC_WIDTH'(sample_i) - (acc_q >> AVG_SHIFT);
        end
    end

    assign avg_o = SENSOR_WIDTH'(acc_q >> AVG_SHIFT);
`endif

    assign state_o.value     = 16'(value_q);
    assign state_o.min       = 16'(min_q);
    assign state_o.max       = 16'(max_q);
    assign state_o.thresh_lo = 16'(lo_q);
    assign state_o.thresh_hi = 16'(hi_q);
    assign state_o.seen      = seen_q;
    assign oor_o             = oor_q;

endmodule

// File: rtl/apb_sensor_monitor.sv
// APB completer monitoring NUM_SENSORS channels with min/max, thresholds and sticky alarms.
// Optional per-channel EMA readback is enabled by SENSOR_MONITOR_AVERAGING_EN.
module apb_sensor_monitor
    import sensor_monitor_pkg::*;
#(
    parameter int NUM_SENSORS  = 8,
    parameter int SENSOR_WIDTH = 16,
    parameter int AVG_SHIFT    = 3
) (
    apb_sensor_monitor_if.slave                 apb,
    input  logic [NUM_SENSORS-1:0]              sensor_valid,
    input  logic [NUM_SENSORS*SENSOR_WIDTH-1:0] sensor_value,
    output logic                                irq
);

    if ($bits(apb.pwdata) != 16) begin : g_bad_dw
        $error("apb_sensor_monitor: APB DATA_WIDTH must be 16");
    end
    if (NUM_SENSORS < 1 || NUM_SENSORS > 16) begin : g_bad_num
        $error("apb_sensor_monitor: NUM_SENSORS must be 1..16");
    end
    if (SENSOR_WIDTH < 1 || SENSOR_WIDTH > 16) begin : g_bad_sw
        $error("apb_sensor_monitor: SENSOR_WIDTH must be 1..16");
    end

    localparam logic [7:0]  NUM_S8 = 8'(NUM_SENSORS);
    localparam logic [15:0] INFO_VAL = {3'b000, 5'(SENSOR_WIDTH), 3'b000, 5'(NUM_SENSORS)};

    apb_state_t             state_q;
    logic                   pready_q, pslverr_q, irq_q;
    logic [15:0]            prdata_q;
    logic [NUM_SENSORS-1:0] status_q, irq_en_q;

    chan_state_t            chan_s [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] oor_s, alarm_set_s, thr_lo_we_s, thr_hi_we_s;
`ifdef SENSOR_MONITOR_AVERAGING_EN
    logic [SENSOR_WIDTH-1:0] avg_s [NUM_SENSORS];
    logic [SENSOR_WIDTH-1:0] sel_avg_s;
`endif

    logic [ADDR_WIDTH-1:0]  ch_rel_s;
    logic [7:0]             ch_idx_s;
    logic [3:0]             ch_off_s;
    logic                   is_chan_s, err_s, wr_commit_s, clr_s;
    logic [15:0]            rdata_s;
    logic [NUM_SENSORS-1:0] w1c_s;
    chan_state_t            sel_s;
    logic                   sel_oor_s;

    assign ch_rel_s  = apb.paddr - CHAN_BASE;
    assign ch_idx_s  = 8'(ch_rel_s[ADDR_WIDTH-1:4]);
    assign ch_off_s  = ch_rel_s[3:0];
    assign is_chan_s = (apb.paddr >= CHAN_BASE);

    // Writes take effect at the edge that closes the pready cycle, unless errored.
    assign wr_commit_s = (state_q == ST_RESP) && apb.psel && apb.penable && apb.pwrite && !pslverr_q;
    assign clr_s       = wr_commit_s && (apb.paddr == REG_CTRL) && apb.pwdata[0];
    assign w1c_s       = (wr_commit_s && (apb.paddr == REG_ALARM_STATUS)) ?
                         apb.pwdata[NUM_SENSORS-1:0] : '0;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
        assign thr_lo_we_s[i] = wr_commit_s && is_chan_s && (ch_idx_s == 8'(i)) && (ch_off_s == CH_THRESH_LO);
        assign thr_hi_we_s[i] = wr_commit_s && is_chan_s && (ch_idx_s == 8'(i)) && (ch_off_s == CH_THRESH_HI);

        sensor_channel_tracker #(
            .SENSOR_WIDTH (SENSOR_WIDTH),
            .AVG_SHIFT    (AVG_SHIFT)
        ) u_tracker (
            .clk         (apb.pclk),
            .rst_n       (apb.preset_n),
            .valid_i     (sensor_valid[i]),
            .sample_i    (sensor_value[i*SENSOR_WIDTH +: SENSOR_WIDTH]),
            .clr_i       (clr_s),
            .thr_lo_we_i (thr_lo_we_s[i]),
            .thr_hi_we_i (thr_hi_we_s[i]),
            .wdata_i     (apb.pwdata[SENSOR_WIDTH-1:0]),
            .state_o     (chan_s[i]),
            .oor_o       (oor_s[i]),
            .alarm_set_o (alarm_set_s[i])
`ifdef SENSOR_MONITOR_AVERAGING_EN
            ,
            .avg_o       (avg_s[i])
`endif
        );
    end

    // Channel select, address decode and readback mux.
    always_comb begin
        sel_s     = '0;
        sel_oor_s = 1'b0;
`ifdef SENSOR_MONITOR_AVERAGING_EN
        sel_avg_s = '0;
`endif
        for (int i = 0; i < NUM_SENSORS; i++) begin
            sel_s     = (ch_idx_s == 8'(i)) ? chan_s[i] : sel_s;
            sel_oor_s = (ch_idx_s == 8'(i)) ? oor_s[i]  : sel_oor_s;
`ifdef SENSOR_MONITOR_AVERAGING_EN
            sel_avg_s = (ch_idx_s == 8'(i)) ? avg_s[i]  : sel_avg_s;
`endif
        end
        rdata_s = 16'h0000;
        err_s   = 1'b0;
        if (apb.paddr[0]) begin
            err_s = 1'b1;
        end else if (!is_chan_s) begin
            case (apb.paddr)
                REG_ALARM_STATUS: rdata_s = 16'(status_q);
                REG_IRQ_EN:       rdata_s = 16'(irq_en_q);
                REG_CTRL:         rdata_s = 16'h0000;
                REG_INFO: begin
                    rdata_s = INFO_VAL;
                    err_s   = apb.pwrite;
                end
                default:          err_s = 1'b1;
            endcase
        end else if (ch_idx_s >= NUM_S8) begin
            err_s = 1'b1;
        end else begin
            case (ch_off_s)
                CH_VALUE:     begin rdata_s = sel_s.value; err_s = apb.pwrite; end
                CH_MIN:       begin rdata_s = sel_s.min;   err_s = apb.pwrite; end
                CH_MAX:       begin rdata_s = sel_s.max;   err_s = apb.pwrite; end
                CH_THRESH_LO: rdata_s = sel_s.thresh_lo;
                CH_THRESH_HI: rdata_s = sel_s.thresh_hi;
                CH_FLAGS:     begin rdata_s = {14'h0000, sel_oor_s, sel_s.seen}; err_s = apb.pwrite; end
`ifdef SENSOR_MONITOR_AVERAGING_EN
                CH_AVG:       begin rdata_s = 16'(sel_avg_s); err_s = apb.pwrite; end
`endif
                default:      err_s = 1'b1;
            endcase
        end
    end

    // APB response FSM: one wait state, pready held for exactly one cycle.
    always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
        if (!apb.preset_n) begin
            state_q   <= ST_IDLE;
            pready_q  <= 1'b0;
            prdata_q  <= 16'h0000;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (apb.psel && apb.penable) begin
                        state_q   <= ST_RESP;
                        pready_q  <= 1'b1;
                        prdata_q  <= err_s ? 16'h0000 : rdata_s;
                        pslverr_q <= err_s;
                    end else begin
                        pready_q  <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state_q  <= ST_IDLE;
                    pready_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    pready_q <= 1'b0;
                end
            endcase
        end
    end

    // Global registers; an alarm set beats a simultaneous W1C of the same bit.
    always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
        if (!apb.preset_n) begin
            status_q <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~w1c_s) | alarm_set_s;
            if (wr_commit_s && (apb.paddr == REG_IRQ_EN)) irq_en_q <= apb.pwdata[NUM_SENSORS-1:0];
            irq_q    <= |(status_q & irq_en_q);
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
    assign irq         = irq_q;

endmodule
